// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use and multi-cycle mul/div stalls, branch flushes.
// Define HAZARD_PERF_EN to add the StallCnt/FlushCnt performance counters.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MulDivE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MDBusy,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
`endif
);
    localparam int CW = $clog2(MD_LAT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_lw_stall;
    logic            w_md_stall;

    assign ForwardAE = (Rs1E == RdM && RegWriteM && Rs1E != '0) ? 2'b10 :
                       (Rs1E == RdW && RegWriteW && Rs1E != '0) ? 2'b01 : 2'b00;
    assign ForwardBE = (Rs2E == RdM && RegWriteM && Rs2E != '0) ? 2'b10 :
                       (Rs2E == RdW && RegWriteW && Rs2E != '0) ? 2'b01 : 2'b00;

    assign w_lw_stall = ResultSrcE0 && RdE != '0 && (Rs1D == RdE || Rs2D == RdE);
    // The final cycle of an op releases E so the next op can enter without a gap.
    assign w_md_stall = (r_state == BUSY) ? (r_cnt > CW'(1)) : (MulDivE && MD_LAT > 1);

    assign StallF = w_lw_stall | w_md_stall;
    assign StallD = StallF;
    assign StallE = w_md_stall;
    assign FlushD = PCSrcE;
    assign FlushE = (w_lw_stall | PCSrcE) & ~w_md_stall;
    assign FlushM = w_md_stall;
    assign MDBusy = (r_state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (MulDivE && MD_LAT > 1) begin
                r_state <= BUSY;
                r_cnt   <= CW'(MD_LAT - 1);
            end
        end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
                r_state <= IDLE;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (PCSrcE)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes and the mul/div FSM.
// Instantiates MD_LAT=4 and MD_LAT=1 copies; counter checks are built with HAZARD_PERF_EN.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MDBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MDBusy1;
    logic [1:0] ForwardAE1, ForwardBE1;
    int         tests = 0;
    int         fails = 0;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt, StallCnt1, FlushCnt1;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MD_LAT(4)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
        .FlushE(FlushE), .FlushM(FlushM), .MDBusy(MDBusy),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .MD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .FlushD(FlushD1),
        .FlushE(FlushE1), .FlushM(FlushM1), .MDBusy(MDBusy1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt1), .FlushCnt(FlushCnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulDivE} = '0;
    endtask

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
    function automatic logic [5:0] sf();
        return {StallF, StallD, StallE, FlushD, FlushE, FlushM};
    endfunction

    initial begin
        reset = 1'b1;
        clear();
        #1;
        chk("reset_all_zero", {sf(), MDBusy, ForwardAE, ForwardBE}, 0);
        chk("reset_all_zero_lat1", {StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MDBusy1, ForwardAE1, ForwardBE1}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // forwarding
        @(negedge clk);
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 chk("fwdA_M", ForwardAE, 2'b10);
        RegWriteM = 0;
        #1 chk("fwdA_W", ForwardAE, 2'b01);
        Rs1E = 0;
        #1 chk("fwdA_x0", ForwardAE, 2'b00);
        Rs2E = 9; RdM = 9; RegWriteM = 1; RdW = 9;
        #1 chk("fwdB_M", ForwardBE, 2'b10);
        RdM = 3;
        #1 chk("fwdB_W", ForwardBE, 2'b01);
        RegWriteW = 0;
        #1 chk("fwdB_none", ForwardBE, 2'b00);
        clear();

        // load-use
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        #1 chk("lw_rs2", sf(), 6'b110010);
        RdE = 0; Rs2D = 0;
        #1 chk("lw_x0", sf(), 6'b000000);
        RdE = 7; Rs1D = 7;
        #1 chk("lw_rs1", sf(), 6'b110010);
        PCSrcE = 1;
        #1 chk("lw_and_branch", sf(), 6'b110110);
        ResultSrcE0 = 0;
        #1 chk("branch_only", sf(), 6'b000110);
        clear();

        // back-to-back mul/div: 8 cycles
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            MulDivE = 1;
            #1;
            chk($sformatf("md_stall_c%0d", i), {StallF, StallD, StallE, FlushM}, (i % 4 == 3) ? 4'b0000 : 4'b1111);
            chk($sformatf("md_busy_c%0d", i), MDBusy, (i % 4 == 0) ? 1'b0 : 1'b1);
            chk($sformatf("md1_nostall_c%0d", i), {StallF1, StallE1, FlushM1, MDBusy1}, 4'b0000);
        end
        @(negedge clk);
        MulDivE = 0;
        #1 chk("md_idle_after", {sf(), MDBusy}, 7'b0);

        // mul/div start with a branch in E: E holds so FlushE is suppressed
        @(negedge clk);
        MulDivE = 1; PCSrcE = 1;
        #1 chk("md_branch", sf(), 6'b111101);
        @(negedge clk);
        MulDivE = 0; PCSrcE = 0;
        #1 chk("md_busy_c1", {MDBusy, StallF}, 2'b11);

        // async reset mid-op
        #2 reset = 1'b1;
        #1 chk("rst_mid_busy", {sf(), MDBusy}, 7'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("post_rst_c%0d", i), {sf(), MDBusy}, 7'b0);
        end

`ifdef HAZARD_PERF_EN
        chk("cnt_after_rst", {StallCnt[15:0], FlushCnt[15:0]}, 0);
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        repeat (3) @(negedge clk);
        ResultSrcE0 = 0; PCSrcE = 1;
        repeat (2) @(negedge clk);
        PCSrcE = 0;
        #1 chk("stall_cnt", StallCnt, 3);
        chk("flush_cnt", FlushCnt, 2);
        dut.r_stall_cnt = 32'hFFFF_FFFF;
        ResultSrcE0 = 1;
        @(negedge clk);
        ResultSrcE0 = 0;
        #1 chk("stall_cnt_wrap", StallCnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MD_LAT, default 4, total E-stage occupancy in cycles of a multi-cycle mul/div op (legal range 1..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports Rs1D, Rs2D  input  REG_AW  D-stage source registers.
REQ-006 SHALL have ports Rs1E, Rs2E, RdE  input  REG_AW  E-stage sources and destination.
REQ-007 SHALL have ports RdM, RdW  input  REG_AW; RegWriteM, RegWriteW  input  1  M/W destination and write enable.
REQ-008 SHALL have ports ResultSrcE0  input  1  (load in E); PCSrcE  input  1  (taken branch/jump in E); MulDivE  input  1  (mul/div op in E).
REQ-009 SHALL have outputs StallF, StallD, StallE, FlushD, FlushE, FlushM, MDBusy  1 each.
REQ-010 SHALL have outputs ForwardAE, ForwardBE  2  operand select: 00 register file, 01 W result, 10 M ALU result.

Function
REQ-011 ForwardAE SHALL be 10 if Rs1E==RdM & RegWriteM & Rs1E!=0, else 01 if Rs1E==RdW & RegWriteW & Rs1E!=0, else 00; ForwardBE identical using Rs2E (M has priority over W).
REQ-012 lwStall SHALL be ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE); a load to x0 SHALL never stall.
REQ-013 Mul/div FSM SHALL have states IDLE and BUSY plus a down-counter cnt of clog2(MD_LAT)+1 bits.
REQ-014 In IDLE with MulDivE=1 and MD_LAT>1: mdStall=1, cnt loads MD_LAT-1, next state BUSY; with MD_LAT==1 FSM SHALL remain IDLE and mdStall=0.
REQ-015 In BUSY: cnt decrements each cycle; mdStall = (cnt>1); when cnt==1 next state SHALL be IDLE; MulDivE SHALL be ignored (no restart).
REQ-016 An op with MD_LAT=N SHALL therefore hold E exactly N cycles; back-to-back mul/div ops SHALL each take N cycles with no gap cycle added.
REQ-017 MDBusy SHALL equal (state==BUSY).
REQ-018 StallF = StallD = lwStall | mdStall; StallE = mdStall.
REQ-019 FlushD = PCSrcE; FlushE = (lwStall | PCSrcE) & ~mdStall; FlushM = mdStall (bubble into M while E holds).
REQ-020 Simultaneous lwStall and PCSrcE SHALL give StallF=StallD=1, FlushD=FlushE=1 (branch flush wins over the squashed D instruction).
REQ-021 Forwarding and all stall/flush outputs SHALL be combinational from current inputs and FSM state (zero latency).

Reset
REQ-022 reset SHALL asynchronously force state IDLE, cnt 0, and any counters to 0; MDBusy SHALL read 0 during reset.
REQ-023 Reset asserted mid-BUSY SHALL abort the op; first cycle after release SHALL be IDLE with no residual stall.
REQ-024 While reset is high with all other inputs 0, every output SHALL be 0.

Configuration
REQ-025 Macro HAZARD_PERF_EN SHALL, when defined, add outputs StallCnt and FlushCnt, 32 bits each.
REQ-026 With HAZARD_PERF_EN: StallCnt SHALL increment on each clk edge where StallF=1; FlushCnt on each edge where PCSrcE=1; both wrap 0xFFFFFFFF->0; both reset to 0.
REQ-027 Without HAZARD_PERF_EN the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; Rs1E=0 -> 00.
REQ-029 Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0; RdE=0 -> no stall.
REQ-030 Mul/div, MD_LAT=4: MulDivE held 4 cycles -> StallF/StallD/StallE/FlushM =1 for cycles 0-2, 0 in cycle 3; MDBusy=1 cycles 1-3; IDLE in cycle 4.
REQ-031 Back-to-back mul/div (MulDivE held 8 cycles, MD_LAT=4) -> stall pattern 1,1,1,0,1,1,1,0; MD_LAT=1 -> no stall ever.
REQ-032 Reset asserted in cycle 1 of a BUSY op -> MDBusy and stalls drop immediately; after release with MulDivE=0, outputs stay 0.
REQ-033 HAZARD_PERF_EN: 3 load-use stall cycles plus 2 PCSrcE cycles -> StallCnt=3, FlushCnt=2; counter preset near 0xFFFFFFFF wraps to 0.
